// File: rtl/fmac_pkg.sv
// Shared definitions for the rx FIFO drain path: FSM encoding, header
// field positions and the word-count helper used when a header is parsed.
package fmac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } drain_state_e;

  localparam int LEN_LSB     = 0;
  localparam int LEN_MSB     = 15;
  localparam int LEN_W       = LEN_MSB - LEN_LSB + 1;
  localparam int MAX_LEN_DEF = 9600;

  typedef logic [LEN_W-1:0] len_t;

  // Number of 8-byte data words needed to carry len bytes (ceil(len/8)).
  function automatic len_t words_for_len(input len_t len);
    logic [LEN_W:0] sum;
    sum = {1'b0, len} + (LEN_W+1)'(7);
    return len_t'(sum >> 3);
  endfunction

endpackage

// File: rtl/fmac_skid2.sv
// Two-entry valid/ready output buffer. The head entry drives the outputs
// directly from flops, so the payload holds while the consumer stalls.
module fmac_skid2 #(
  parameter int PW = 74
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data,
  output logic [1:0]    count
);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          push;
  logic          pop;

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = head_q;
  assign count     = cnt_q;

  // Next-state of the two entries: the head only changes when it leaves or the buffer is empty.
  always_comb begin
    push   = in_valid && (cnt_q != 2'd2);
    pop    = (cnt_q != 2'd0) && out_ready;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case (cnt_q)
      2'd0: begin
        if (push) begin
          head_d = in_data;
          cnt_d  = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = in_data;
        end else if (push) begin
          tail_d = in_data;
          cnt_d  = 2'd2;
        end else if (pop) begin
          cnt_d  = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          head_d = tail_q;
          cnt_d  = 2'd1;
        end
      end
      default: cnt_d = 2'd0;
    endcase
  end

  // Buffer storage and occupancy, cleared on reset so the outputs read zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/fmac_rxfifo_drain.sv
// Drains header-prefixed packets from the rx FIFO: the header word gives
// the byte length, is consumed here, and the data words are forwarded with
// sop/eop/byte-enable framing through a two-entry output buffer.
module fmac_rxfifo_drain
  import fmac_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int PTR     = 12,
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               fifo_rdreq,
  input  logic [WIDTH-1:0]   fifo_q,
  input  logic               fifo_rdempty,
  input  logic [PTR:0]       fifo_rdusedw,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_sop,
  output logic               out_eop,
  output logic [WIDTH/8-1:0] out_be,
  output logic [CNT_W-1:0]   pkt_cnt,
  output logic               err_len
);

  localparam int BE_W = WIDTH / 8;
  localparam int PW   = WIDTH + BE_W + 2;

  drain_state_e     state_q, state_d;
  len_t             req_q, req_d;
  len_t             rem_q, rem_d;
  logic [2:0]       tail_q, tail_d;
  logic             first_q, first_d;
  logic             inflight_q, inflight_d;
  logic             en_q;
  logic             err_q, err_d;
  logic [CNT_W-1:0] pkt_q, pkt_d;

  len_t             hdr_len;
  len_t             hdr_words;
  logic             hdr_legal;
  logic             rd_req;
  logic             room;
  logic [2:0]       avail;
  logic             out_pop;
  logic             push;
  logic             last_word;
  logic [BE_W-1:0]  last_be;
  logic [BE_W-1:0]  in_be;
  logic             buf_in_ready;
  logic [1:0]       buf_cnt;
  logic [PW-1:0]    buf_in;
  logic [PW-1:0]    buf_out;
  logic             unused_usedw;

  assign unused_usedw = ^fifo_rdusedw;

  assign hdr_len   = fifo_q[LEN_MSB:LEN_LSB];
  assign hdr_words = words_for_len(hdr_len);
  assign hdr_legal = (hdr_len != '0) && (32'(hdr_len) <= 32'(MAX_LEN));

  assign out_pop   = out_valid && out_ready;
  assign avail     = {1'b0, buf_cnt} + {2'b0, inflight_q} - {2'b0, out_pop};
  assign room      = (avail < 3'd2);
  assign push      = inflight_q && buf_in_ready;
  assign last_word = (rem_q == len_t'(1));

  // Byte enables of the closing word: a whole word when len is a multiple of 8.
  always_comb begin
    if (tail_q == 3'd0) begin
      last_be = '1;
    end else begin
      last_be = BE_W'((32'd1 << tail_q) - 32'd1);
    end
    in_be = last_word ? last_be : '1;
  end

  assign buf_in = {first_q, last_word, in_be, fifo_q};

  // Pop request: header pops from IDLE, data pops only while the buffer plus the word in flight leave room.
  always_comb begin
    rd_req = 1'b0;
    case (state_q)
      ST_IDLE: rd_req = en_q && !fifo_rdempty;
      ST_HDR:  rd_req = en_q && hdr_legal && !fifo_rdempty && room;
      ST_DATA: rd_req = en_q && (req_q != '0) && !fifo_rdempty && room;
      default: rd_req = 1'b0;
    endcase
  end

  assign fifo_rdreq = rd_req;

  // FSM next state and counters; a data pop becomes a buffer write one cycle later.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    rem_d      = rem_q;
    tail_d     = tail_q;
    first_d    = first_q;
    err_d      = 1'b0;
    inflight_d = rd_req && (state_q != ST_IDLE);
    pkt_d      = pkt_q + CNT_W'(out_pop && out_eop);
    case (state_q)
      ST_IDLE: begin
        if (rd_req) begin
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (hdr_legal) begin
          state_d = ST_DATA;
          req_d   = hdr_words - len_t'(rd_req);
          rem_d   = hdr_words;
          tail_d  = hdr_len[2:0];
          first_d = 1'b1;
        end else begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (rd_req) begin
          req_d = req_q - len_t'(1);
        end
        if (push) begin
          first_d = 1'b0;
          rem_d   = rem_q - len_t'(1);
          if (last_word) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; en_q holds off the first pop until one edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      rem_q      <= '0;
      tail_q     <= 3'd0;
      first_q    <= 1'b0;
      inflight_q <= 1'b0;
      en_q       <= 1'b0;
      err_q      <= 1'b0;
      pkt_q      <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      rem_q      <= rem_d;
      tail_q     <= tail_d;
      first_q    <= first_d;
      inflight_q <= inflight_d;
      en_q       <= 1'b1;
      err_q      <= err_d;
      pkt_q      <= pkt_d;
    end
  end

  assign err_len = err_q;
  assign pkt_cnt = pkt_q;

  fmac_skid2 #(
    .PW(PW)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (push),
    .in_ready (buf_in_ready),
    .in_data  (buf_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (buf_out),
    .count    (buf_cnt)
  );

  assign {out_sop, out_eop, out_be, out_data} = buf_out;

endmodule

// File: doc/fmac_rxfifo_drain.md
FMAC_RXFIFO_DRAIN -- requirements
Module: fmac_rxfifo_drain

Interface
REQ-001 SHALL have parameter WIDTH, default 64, FIFO data width.
REQ-002 SHALL have parameter PTR, default 12, FIFO pointer width; the usedw port is PTR+1 bits wide.
REQ-003 SHALL have parameter MAX_LEN, default 9600, maximum legal packet byte length.
REQ-004 SHALL have parameter CNT_W, default 16, packet counter width.
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 fifo_rdreq  out  1  pop request to the rx FIFO; fifo_q is valid the cycle after.
REQ-008 fifo_q  in  WIDTH  FIFO read data.
REQ-009 fifo_rdempty  in  1  FIFO empty.
REQ-010 fifo_rdusedw  in  PTR+1  FIFO occupancy (status only, unused for flow control).
REQ-011 out_valid  out  1  output word valid.
REQ-012 out_ready  in  1  downstream accepts the word when out_valid && out_ready.
REQ-013 out_data  out  WIDTH  packet data word.
REQ-014 out_sop  out  1  first word of packet.
REQ-015 out_eop  out  1  last word of packet.
REQ-016 out_be  out  WIDTH/8  byte enables, bit0 = byte[7:0]; all-ones except on the eop word.
REQ-017 pkt_cnt  out  CNT_W  packets fully delivered, wraps modulo 2^CNT_W.
REQ-018 err_len  out  1  one-cycle pulse on an illegal header.

Function
REQ-019 SHALL treat each packet in the FIFO as one header word followed by ceil(len/8) data words, with len = header[15:0]; header bits [63:16] are ignored.
REQ-020 SHALL consume the header internally and never forward it to the output.
REQ-021 SHALL implement states IDLE, HDR, DATA.
REQ-022 IDLE -> HDR: when !fifo_rdempty, assert fifo_rdreq for one cycle.
REQ-023 HDR: capture fifo_q on the following cycle; if 1 <= len <= MAX_LEN, load the request counter and remaining-word counter with ceil(len/8) and go to DATA.
REQ-024 HDR with an illegal len: pulse err_len, drop the header word only, and return to IDLE.
REQ-025 DATA: assert fifo_rdreq only when !fifo_rdempty && words_to_request > 0 && (buffer occupancy + reads in flight) < 2.
REQ-026 SHALL never lose or duplicate a word, and never issue fifo_rdreq while fifo_rdempty = 1.
REQ-027 DATA -> IDLE: on the cycle the last data word is written into the output buffer.
REQ-028 The next header read MAY start while the previous packet still drains from the buffer.
REQ-029 out_sop SHALL be set on the first data word of each packet.
REQ-030 out_eop SHALL be set on word number ceil(len/8) of each packet.
REQ-031 On the eop word, out_be SHALL be 8'hFF if len%8 == 0, else (1<<(len%8))-1.
REQ-032 out_data, out_sop, out_eop and out_be SHALL hold stable while out_valid && !out_ready.
REQ-033 Sustained throughput SHALL be 1 word/clk with FIFO non-empty and out_ready = 1.
REQ-034 Latency SHALL be 3 clk from header pop to first out_valid: header pop, first data pop, data registered.
REQ-035 pkt_cnt SHALL increment on the out_eop handshake.

Reset
REQ-036 On rst_n = 0, state SHALL be IDLE and all counters and the buffer SHALL be cleared.
REQ-037 On rst_n = 0, all outputs SHALL be 0: fifo_rdreq, out_valid, out_sop, out_eop, out_be, out_data, pkt_cnt, err_len.
REQ-038 Reset mid-packet SHALL abandon the packet with no partial-packet recovery; the FIFO is cleared by its own aclr, driven by the same system reset.
REQ-039 After rst_n deasserts, the first fifo_rdreq SHALL occur no earlier than the second rising edge.

Structure
REQ-040 Shared package fmac_pkg SHALL hold the state encoding typedef, header field positions (LEN_LSB = 0, LEN_MSB = 15) and the default MAX_LEN.
REQ-041 The 2-entry output buffer SHALL be a sub-module fmac_skid2 (valid/ready, WIDTH + WIDTH/8 + 2 payload bits).

Verification
REQ-042 Header len = 64, 8 data words, out_ready = 1 -> 8 consecutive out_valid beats, sop on beat 1, eop on beat 8, out_be = 8'hFF, pkt_cnt = 1.
REQ-043 Header len = 13, 2 words -> eop on beat 2 with out_be = 8'h1F.
REQ-044 len = 1 -> single beat with sop = eop = 1 and out_be = 8'h01.
REQ-045 len = 0, then len = 9601, then a legal len = 16 -> two err_len pulses, then a 2-beat packet with no stray data.
REQ-046 out_ready toggling 1010... on a 100-word packet -> data matches FIFO order, no fifo_rdreq while empty, at most 2 words buffered.
REQ-047 rst_n asserted at word 4 of a 10-word packet -> all outputs 0 asynchronously; after release with a refilled FIFO, the next packet starts with sop and pkt_cnt counts from 0.
